// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and sequencer state encodings shared by the
// shared-ALU arbiter, its ALU core and anything that builds requests for it.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/grant/result bundle between the requesters
// (master side) and the shared-ALU arbiter (slave side). Per-requester
// fields are packed with requester i in slice i.
interface alu_share_arb_if #(
  parameter int N    = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] op;
  logic [N*NREQ-1:0] a_in;
  logic [N*NREQ-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      res;
  logic [NREQ-1:0]   res_valid;
  logic              busy;

  modport master (
    output req, op, a_in, b_in,
    input  gnt, res, res_valid, busy
  );

  modport slave (
    input  req, op, a_in, b_in,
    output gnt, res, res_valid, busy
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU. SUB and SLT share the one subtractor;
// SLT is the sign bit of the wrapped difference with no overflow correction.
// Reserved opcodes produce zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);

  logic [N-1:0] diff;

  assign diff = a - b;

  // Opcode decode onto the shared adder/subtractor and bitwise units.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(N-1){1'b0}}, diff[N-1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: arbitrates NREQ requesters onto one shared ALU core.
// IDLE picks a winner and latches its operands, EXEC pulses gnt while the
// core evaluates, RESP presents the registered result with a one-hot
// res_valid. Configuration macro ALU_ARB_RR_EN selects round-robin
// arbitration (search from pointer+1); without it, lowest index wins and
// no pointer register exists.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_share_arb_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [2:0]      op_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [IW-1:0]   win_q;
  logic [N-1:0]    alu_res;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  int              cand;
  logic [NREQ-1:0] one;

  assign one = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0] ptr;

  // Round-robin winner search starting one past the last winner.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + 1 + k) % NREQ;
      if (!win_any && bus.req[cand]) begin
        win_any = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end
`else
  // Fixed-priority winner search, lowest index first.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = k;
      if (!win_any && bus.req[cand]) begin
        win_any = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end
`endif

  alu_core #(.N(N)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  // Sequencer FSM with all outputs registered; operands are captured only
  // on the IDLE->EXEC transition so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.gnt       <= '0;
      bus.res_valid <= '0;
      bus.res       <= '0;
      bus.busy      <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      win_q         <= '0;
`ifdef ALU_ARB_RR_EN
      ptr           <= IW'(NREQ - 1);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bus.res_valid <= '0;
          if (win_any) begin
            op_q     <= bus.op[3*int'(win_idx) +: 3];
            a_q      <= bus.a_in[N*int'(win_idx) +: N];
            b_q      <= bus.b_in[N*int'(win_idx) +: N];
            win_q    <= win_idx;
            bus.gnt  <= one << win_idx;
            bus.busy <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.gnt       <= '0;
          bus.res       <= alu_res;
          bus.res_valid <= one << win_q;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          bus.res_valid <= '0;
          bus.busy      <= 1'b0;
`ifdef ALU_ARB_RR_EN
          ptr           <= win_q;
`endif
          state         <= ST_IDLE;
        end
        default: begin
          bus.gnt       <= '0;
          bus.res_valid <= '0;
          bus.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb at N=8,
// NREQ=2. Expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N    = 8;
  localparam int NREQ = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_share_arb_if #(.N(N), .NREQ(NREQ)) bus ();

  alu_share_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    bus.op[3*r +: 3]   = o;
    bus.a_in[N*r +: N] = a;
    bus.b_in[N*r +: N] = b;
    bus.req[r]         = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;
    tick(); tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
    checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL reset_rv got=%b exp=00", bus.res_valid); end
    checks++; if (bus.res !== 8'h00) begin errors++; $display("FAIL reset_res got=%h exp=00", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_ops();
    vec_t v [8];
    logic [1:0] exp_oh;
    v[0] = '{0, OP_SLT, 8'h03, 8'h05, 8'h01};
    v[1] = '{0, OP_SLT, 8'h80, 8'h01, 8'h00};
    v[2] = '{0, OP_SUB, 8'h00, 8'h01, 8'hFF};
    v[3] = '{1, OP_ADD, 8'hFF, 8'h02, 8'h01};
    v[4] = '{1, OP_AND, 8'hF0, 8'h3C, 8'h30};
    v[5] = '{0, OP_OR,  8'hF0, 8'h3C, 8'hFC};
    v[6] = '{1, OP_XOR, 8'hF0, 8'h3C, 8'hCC};
    v[7] = '{1, OP_SLT, 8'h01, 8'h02, 8'h01};
    for (int i = 0; i < 8; i++) begin
      exp_oh = 2'b01 << v[i].r;
      drive(v[i].r, v[i].op, v[i].a, v[i].b);
      tick();
      checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL op%0d_gnt got=%b exp=%b", i, bus.gnt, exp_oh); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL op%0d_busy got=%b exp=1", i, bus.busy); end
      bus.req = '0;
      tick();
      checks++; if (bus.res_valid !== exp_oh) begin errors++; $display("FAIL op%0d_rv got=%b exp=%b", i, bus.res_valid, exp_oh); end
      checks++; if (bus.res !== v[i].exp) begin errors++; $display("FAIL op%0d_res got=%h exp=%h", i, bus.res, v[i].exp); end
      checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL op%0d_gnt_drop got=%b exp=00", i, bus.gnt); end
      tick();
      checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL op%0d_rv_drop got=%b exp=00", i, bus.res_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL op%0d_idle_busy got=%b exp=0", i, bus.busy); end
      checks++; if (bus.res !== v[i].exp) begin errors++; $display("FAIL op%0d_res_hold got=%h exp=%h", i, bus.res, v[i].exp); end
    end
  endtask

  task automatic test_reserved_op();
    drive(0, 3'b110, 8'h55, 8'hAA);
    tick();
    bus.req = '0;
    tick();
    checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL rsvd_rv got=%b exp=01", bus.res_valid); end
    checks++; if (bus.res !== 8'h00) begin errors++; $display("FAIL rsvd_res got=%h exp=00", bus.res); end
    tick();
  endtask

  task automatic test_operand_capture();
    drive(0, OP_ADD, 8'h10, 8'h01);
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL cap_gnt got=%b exp=01", bus.gnt); end
    bus.a_in[7:0] = 8'h20;
    bus.req = '0;
    tick();
    checks++; if (bus.res !== 8'h11) begin errors++; $display("FAIL cap_res got=%h exp=11", bus.res); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    drive(1, OP_ADD, 8'h40, 8'h01);
    tick();
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rmid_gnt got=%b exp=10", bus.gnt); end
    bus.req = '0;
    rst = 1'b1;
    tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rmid_gnt0 got=%b exp=00", bus.gnt); end
    checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL rmid_rv got=%b exp=00", bus.res_valid); end
    checks++; if (bus.res !== 8'h00) begin errors++; $display("FAIL rmid_res got=%h exp=00", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    tick();
    checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL rmid_no_rv got=%b exp=00", bus.res_valid); end
    drive(0, OP_ADD, 8'h01, 8'h01);
    drive(1, OP_ADD, 8'h02, 8'h02);
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rmid_first_gnt got=%b exp=01", bus.gnt); end
    bus.req = '0;
    tick();
    checks++; if (bus.res !== 8'h02) begin errors++; $display("FAIL rmid_first_res got=%h exp=02", bus.res); end
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_oh;
    logic [7:0] exp_res;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, OP_ADD, 8'h01, 8'h01);
    drive(1, OP_ADD, 8'h02, 8'h02);
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_RR_EN
      exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_oh = 2'b01;
`endif
      exp_res = (exp_oh == 2'b01) ? 8'h02 : 8'h04;
      tick();
      checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL arb%0d_gnt got=%b exp=%b", g, bus.gnt, exp_oh); end
      tick();
      checks++; if (bus.res_valid !== exp_oh) begin errors++; $display("FAIL arb%0d_rv got=%b exp=%b", g, bus.res_valid, exp_oh); end
      checks++; if (bus.res !== exp_res) begin errors++; $display("FAIL arb%0d_res got=%h exp=%h", g, bus.res, exp_res); end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_alu_ops();
    test_reserved_op();
    test_operand_capture();
    test_reset_mid_op();
    test_arbitration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shared-ALU arbiter and sequencer for the RISC execute stage. Accepts operation requests from NREQ requesters (e.g. main ALU path, branch-compare path, address-generation path), grants one at a time, captures its operands, drives a single combinational ALU core (ADD/SUB/AND/OR/XOR/SLT) and returns a registered result with a per-requester valid pulse. It replaces per-path duplicated subtract/compare units with one time-shared resource.

## Interface
- N, 32, operand/result width (≥2)
- NREQ, 2, number of requesters (2..4)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; bit i held high with operands stable until gnt[i] seen
- op  in  3*NREQ  opcode of requester i at bits [3i+2:3i]
- a_in  in  N*NREQ  operand A of requester i at [N*i+N-1:N*i]
- b_in  in  N*NREQ  operand B, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured
- res  out  N  registered result, valid while res_valid nonzero
- res_valid  out  NREQ  one-hot, one-cycle pulse to the served requester
- busy  out  1  high in EXEC and RESP

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110/111 reserved -> result 0.
- Arithmetic modulo 2^N; carries/overflow discarded.
- SLT: res[0] = bit N-1 of (A-B) mod 2^N, res[N-1:1] = 0. No overflow correction (0x80 vs 0x01 at N=8 gives 0).
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: if any req, select winner, latch op/A/B/winner index, go EXEC; else stay.
  - EXEC: gnt[winner]=1; ALU core evaluates latched operands; result registered at end of cycle; go RESP.
  - RESP: res_valid[winner]=1, res driven; round-robin pointer := winner; go IDLE.
- req seen during EXEC/RESP is ignored; req still high on return to IDLE is a new request. Requesters drop req no later than the cycle after gnt.
- Operands are sampled only on the IDLE->EXEC edge; later changes have no effect on the in-flight op.

## Timing
- Request sampled in IDLE cycle t: gnt at t+1, res/res_valid at t+2, IDLE again at t+3. Latency 2 cycles, throughput 1 op / 3 cycles.
- Reset (any state, including mid-op): state IDLE, gnt=0, res_valid=0, res=0, busy=0, pointer = NREQ-1 (requester 0 wins first). In-flight op discarded, no res_valid issued.
- res holds its last value until the next RESP; consumers sample only on res_valid.
- Simultaneous requests: exactly one winner per arbitration; losers stay pending, no gnt.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; search starts at pointer+1 modulo NREQ, so a requester that just won has lowest priority next time.
- Not defined: fixed priority, lowest index wins; pointer register removed. Starvation of higher indices under continuous req 0 is accepted.

## Structure
- Shared package alu_pkg: opcode constants (OP_ADD..OP_SLT), FSM state encodings (ST_IDLE, ST_EXEC, ST_RESP, 2-bit).
- Sub-module alu_core #(N): purely combinational, inputs op/A/B, output result; SUB and SLT share one subtractor. Arbiter, FSM and registers live in alu_share_arb.

## Test plan
- N=8, req=01, op0=SLT, A=3, B=5 -> gnt=01 at t+1, res=0x01 with res_valid=01 at t+2.
- N=8, SLT A=0x80, B=0x01 -> res=0x00; SUB A=0x00, B=0x01 -> res=0xFF; ADD 0xFF+0x02 -> 0x01.
- req=11 held continuously with RR_EN -> grants alternate 01,10,01,10; without RR_EN -> every grant 01.
- rst asserted in EXEC of an op -> next cycle all outputs 0, no res_valid; first grant after reset to requester 0.
- Change a_in during EXEC (0x10 -> 0x20), op ADD B=1 -> res=0x11 (captured value used).
- Reserved op 110, A=0x55, B=0xAA -> res=0x00, res_valid pulses normally.
